// File: rtl/gate_pkg.sv
// Shared types and constants for the parking barrier arbiter.
//   state_t   : barrier sequencing states
//   ST_*      : status codes driven to the RGB decoder / 7-segment mux
//   DIR_*     : served direction encoding used by the round-robin pointer
package gate_pkg;

    localparam int unsigned STATUS_W = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_PASS  = 3'd2,
        S_HOLD  = 3'd3,
        S_MAINT = 3'd4
    } state_t;

    localparam logic [STATUS_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATUS_W-1:0] ST_IN    = 3'd1;
    localparam logic [STATUS_W-1:0] ST_OUT   = 3'd2;
    localparam logic [STATUS_W-1:0] ST_PASS  = 3'd3;
    localparam logic [STATUS_W-1:0] ST_HOLD  = 3'd4;
    localparam logic [STATUS_W-1:0] ST_FULL  = 3'd5;
    localparam logic [STATUS_W-1:0] ST_MAINT = 3'd6;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // Status shown while the barrier is closed and idle.
    function automatic logic [STATUS_W-1:0] idle_status(input logic full);
        return full ? ST_FULL : ST_IDLE;
    endfunction

endpackage

// File: rtl/gate_arbiter_tick_timer.sv
// Tick-driven counter shared by the OPEN and HOLD timeouts.
//   i_clock, i_reset : clock, async active-high reset
//   i_clear          : synchronous clear (priority over tick)
//   i_tick           : count enable pulse
//   i_limit          : terminal value to compare against
//   o_match_c        : combinational, counter equals i_limit
module tick_timer #(
    parameter int unsigned TW = 5
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_tick,
    input  logic [TW-1:0] i_limit,
    output logic          o_match_c
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_match_c = (r_cnt == i_limit);

endmodule

// File: rtl/gate_arbiter.sv
// Parking barrier arbiter: round-robin entry/exit service, occupancy count
// with capacity limit, open/hold timeouts and maintenance override.
//   i_clock, i_reset        : clock, async active-high reset
//   i_tick                  : slow enable pulse from the divider
//   i_req_in, i_req_out     : entry (access granted) / exit (button) requests
//   i_sensor                : vehicle under the barrier
//   i_maint                 : maintenance override
//   o_gate_open             : barrier open command
//   o_gnt_in, o_gnt_out     : direction currently served
//   o_full, o_count         : occupancy
//   o_status                : display / RGB code
//   o_timeout_evt           : one-cycle pulse when an OPEN times out
module gate_arbiter
    import gate_pkg::*;
#(
    parameter int unsigned CAPACITY = 9,
    parameter int unsigned CW       = 4,
    parameter int unsigned OPEN_T   = 10,
    parameter int unsigned HOLD_T   = 3,
    parameter int unsigned TW       = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_tick,
    input  logic                i_req_in,
    input  logic                i_req_out,
    input  logic                i_sensor,
    input  logic                i_maint,
    output logic                o_gate_open,
    output logic                o_gnt_in,
    output logic                o_gnt_out,
    output logic                o_full,
    output logic [CW-1:0]       o_count,
    output logic [STATUS_W-1:0] o_status,
    output logic                o_timeout_evt
);

    localparam logic [CW-1:0] CAP_CNT  = CW'(CAPACITY);
    localparam logic [TW-1:0] OPEN_LIM = TW'(OPEN_T - 1);
    localparam logic [TW-1:0] HOLD_LIM = TW'(HOLD_T - 1);

    state_t                r_state;
    logic                  r_last_dir;
    logic                  r_gate_open;
    logic                  r_gnt_in;
    logic                  r_gnt_out;
    logic                  r_full;
    logic [CW-1:0]         r_count;
    logic [STATUS_W-1:0]   r_status;
    logic                  r_timeout_evt;

    logic                  w_in_ok;
    logic                  w_out_ok;
    logic                  w_match;
    logic                  w_tmr_clr;
    logic [TW-1:0]         w_limit;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_full_nxt;

    assign w_in_ok  = i_req_in & ~r_full;
    assign w_out_ok = i_req_out & (r_count != '0);

    // Timer only runs in OPEN/HOLD; it is zeroed whenever those states are
    // left or not occupied, so it is always 0 on entry to either.
    assign w_limit   = (r_state == S_HOLD) ? HOLD_LIM : OPEN_LIM;
    assign w_tmr_clr = i_maint | i_sensor | (i_tick & w_match)
                     | ~((r_state == S_OPEN) | (r_state == S_HOLD));

    tick_timer #(.TW(TW)) u_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (w_tmr_clr),
        .i_tick    (i_tick),
        .i_limit   (w_limit),
        .o_match_c (w_match)
    );

    // Occupancy update on the falling sensor edge in PASS; maintenance wins.
    always_comb begin
        w_count_nxt = r_count;
        if (!i_maint && (r_state == S_PASS) && !i_sensor) begin
            if (r_last_dir == DIR_IN) begin
                if (r_count != CAP_CNT) w_count_nxt = r_count + CW'(1);
            end else begin
                if (r_count != '0) w_count_nxt = r_count - CW'(1);
            end
        end
    end

    assign w_full_nxt = (w_count_nxt == CAP_CNT);

    // Barrier sequencer with registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_last_dir    <= DIR_OUT;   // entry wins the first tie
            r_gate_open   <= 1'b0;
            r_gnt_in      <= 1'b0;
            r_gnt_out     <= 1'b0;
            r_full        <= 1'b0;
            r_count       <= '0;
            r_status      <= ST_IDLE;
            r_timeout_evt <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            r_full        <= w_full_nxt;
            r_timeout_evt <= 1'b0;
            if (i_maint) begin
                r_state     <= S_MAINT;
                r_gate_open <= 1'b1;
                r_gnt_in    <= 1'b0;
                r_gnt_out   <= 1'b0;
                r_status    <= ST_MAINT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_in_ok && (!w_out_ok || (r_last_dir == DIR_OUT))) begin
                            r_state     <= S_OPEN;
                            r_gate_open <= 1'b1;
                            r_gnt_in    <= 1'b1;
                            r_last_dir  <= DIR_IN;
                            r_status    <= ST_IN;
                        end else if (w_out_ok) begin
                            r_state     <= S_OPEN;
                            r_gate_open <= 1'b1;
                            r_gnt_out   <= 1'b1;
                            r_last_dir  <= DIR_OUT;
                            r_status    <= ST_OUT;
                        end else begin
                            r_status    <= idle_status(w_full_nxt);
                        end
                    end
                    S_OPEN: begin
                        if (i_sensor) begin
                            r_state  <= S_PASS;
                            r_status <= ST_PASS;
                        end else if (i_tick && w_match) begin
                            r_state       <= S_IDLE;
                            r_gate_open   <= 1'b0;
                            r_gnt_in      <= 1'b0;
                            r_gnt_out     <= 1'b0;
                            r_timeout_evt <= 1'b1;
                            r_status      <= idle_status(w_full_nxt);
                        end
                    end
                    S_PASS: begin
                        if (!i_sensor) begin
                            r_state  <= S_HOLD;
                            r_status <= ST_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (i_sensor) begin
                            r_state  <= S_PASS;
                            r_status <= ST_PASS;
                        end else if (i_tick && w_match) begin
                            r_state     <= S_IDLE;
                            r_gate_open <= 1'b0;
                            r_gnt_in    <= 1'b0;
                            r_gnt_out   <= 1'b0;
                            r_status    <= idle_status(w_full_nxt);
                        end
                    end
                    S_MAINT: begin
                        r_state     <= S_IDLE;
                        r_gate_open <= 1'b0;
                        r_status    <= idle_status(w_full_nxt);
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_gate_open <= 1'b0;
                        r_gnt_in    <= 1'b0;
                        r_gnt_out   <= 1'b0;
                        r_status    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_gate_open   = r_gate_open;
    assign o_gnt_in      = r_gnt_in;
    assign o_gnt_out     = r_gnt_out;
    assign o_full        = r_full;
    assign o_count       = r_count;
    assign o_status      = r_status;
    assign o_timeout_evt = r_timeout_evt;

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed vector bench for gate_arbiter (CAPACITY=3, OPEN_T=4, HOLD_T=2).
module tb_gate_arbiter;

    localparam int unsigned CW = 4;

    typedef struct {
        logic          tk, ri, ro, se, mt;
        logic          g, gi, go, fu;
        logic [CW-1:0] cnt;
        logic [2:0]    st;
        logic          to;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          tick, req_in, req_out, sensor, maint;
    logic          gate_open, gnt_in, gnt_out, full, timeout_evt;
    logic [CW-1:0] count;
    logic [2:0]    status;

    int n_total = 0;
    int n_pass  = 0;

    vec_t tbl[$];

    gate_arbiter #(
        .CAPACITY(3), .CW(CW), .OPEN_T(4), .HOLD_T(2), .TW(5)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_tick        (tick),
        .i_req_in      (req_in),
        .i_req_out     (req_out),
        .i_sensor      (sensor),
        .i_maint       (maint),
        .o_gate_open   (gate_open),
        .o_gnt_in      (gnt_in),
        .o_gnt_out     (gnt_out),
        .o_full        (full),
        .o_count       (count),
        .o_status      (status),
        .o_timeout_evt (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic tk, ri, ro, se, mt,
                                input logic g, gi, go, fu,
                                input int cnt, input int st, input logic to);
        vec_t v;
        v.tk = tk; v.ri = ri; v.ro = ro; v.se = se; v.mt = mt;
        v.g = g; v.gi = gi; v.go = go; v.fu = fu;
        v.cnt = CW'(cnt); v.st = 3'(st); v.to = to;
        return v;
    endfunction

    // Packed view {gate, gnt_in, gnt_out, full, count, status, timeout}
    function automatic logic [11:0] pack_exp(input vec_t v);
        return {v.g, v.gi, v.go, v.fu, v.cnt, v.st, v.to};
    endfunction

    task automatic chk(input string nm, input logic [11:0] exp_v);
        logic [11:0] act;
        act = {gate_open, gnt_in, gnt_out, full, count, status, timeout_evt};
        n_total++;
        if (act !== exp_v)
            $display("FAIL %s: got g/gi/go/full=%b cnt=%0d st=%0d to=%b, want g/gi/go/full=%b cnt=%0d st=%0d to=%b",
                     nm, act[11:8], act[7:4], act[3:1], act[0],
                     exp_v[11:8], exp_v[7:4], exp_v[3:1], exp_v[0]);
        else
            n_pass++;
    endtask

    task automatic drive(input logic tk, ri, ro, se, mt);
        tick = tk; req_in = ri; req_out = ro; sensor = se; maint = mt;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 12'h000);
        rst = 1'b0;

        //        tk ri ro se mt   g gi go fu cnt st to
        // entry cycle
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 1, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0));
        // tie after entry -> exit first, then time out in OPEN
        tbl.push_back(mk(0, 1, 1, 0, 0,  1, 0, 1, 0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,  1, 0, 1, 0, 1, 2, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,  1, 0, 1, 0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,  1, 0, 1, 0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,  1, 0, 1, 0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 1));
        // next tie -> entry; pulse was single
        tbl.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 0, 1, 1, 0));
        // pass (ticks ignored), tailgate, fill to capacity
        tbl.push_back(mk(1, 0, 0, 1, 0,  1, 1, 0, 0, 1, 3, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0,  1, 1, 0, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 1, 0, 0, 2, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 1, 3, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 1, 3, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 5, 0));
        // full: entry refused, exit granted
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 1, 3, 5, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,  1, 0, 1, 1, 3, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 0, 1, 1, 3, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 0, 2, 4, 0));
        // maintenance from HOLD
        tbl.push_back(mk(1, 0, 0, 0, 1,  1, 0, 0, 0, 2, 6, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1,  1, 0, 0, 0, 2, 6, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0));
        // maintenance preempts a pending count update in PASS
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 1, 0, 0, 2, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0, 2, 6, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].tk, tbl[i].ri, tbl[i].ro, tbl[i].se, tbl[i].mt);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), pack_exp(tbl[i]));
        end

        // async reset during OPEN clears outputs without a clock edge
        drive(0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("open_before_reset", 12'b1_1_0_0_0010_001_0);
        drive(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 12'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // empty: exit request ignored
        drive(0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("empty_exit_ignored", 12'h000);

        // after reset the pointer favours entry
        drive(0, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("entry_after_reset", 12'b1_1_0_0_0000_001_0);

        drive(0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
